fp_multiplier: RTL and testbench
================================

Name: fp_multiplier

Overview:
- Multi-cycle IEEE-754 single-precision multiplier. It is the multiplicative counterpart to the FPU's sequential divider.
- Uses the same start/done handshake and 32-bit operand/result format, so the FPU top can issue mul and div through identical control.
- Mantissa product is formed by a 24-iteration shift-and-add datapath, one partial product per clock.

Parameters:
- MANT_W, 24, mantissa width including hidden bit; fixes the iteration count and the product width (2*MANT_W).
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  32  multiplicand, IEEE-754 single.
- b  input  32  multiplier, IEEE-754 single.
- start  input  1  request; sampled only in IDLE.
- result  output  32  product; held stable between done pulses.
- done  output  1  one-cycle pulse when result is updated.
- busy  output  1  high from start acceptance until the cycle done is asserted.

Behaviour:
- Reset (async, rst=1): state=IDLE, result=0, done=0, busy=0, internal counters and accumulator cleared. Reset mid-operation aborts with no done pulse.
- State machine: IDLE -> MULTIPLY -> NORMALIZE -> PACK -> IDLE.
- IDLE:
  - done=0 except in the cycle following PACK.
  - On start=1, latch a and b, set busy=1 and cnt=0, then go to MULTIPLY.
  - start in any other state is ignored (no queueing).
- Operand capture:
  - sign = a[31]^b[31].
  - exp = a[30:23] + b[30:23] - BIAS, computed in 10-bit signed so overflow/underflow are detectable.
  - mantA = {1,a[22:0]}, mantB = {1,b[22:0]}, product accumulator (48b) = 0.
- MULTIPLY:
  - Each cycle, if mantB[cnt]=1, add mantA<<cnt into the accumulator; then cnt++.
  - After exactly MANT_W cycles, go to NORMALIZE.
- NORMALIZE: product is in [1,4).
  - If p[47]=1: frac = p[46:24], exp+1.
  - Otherwise: frac = p[45:23].
  - Go to PACK.
- PACK: register result, pulse done=1, clear busy, return to IDLE. Priority order for result:
  - NaN input (exp field 255, frac≠0), or inf×zero: 0x7FC00000.
  - Either operand inf: {sign,8'hFF,23'b0}.
  - Either exp field 0 (zero/denormal flushed to zero): {sign,31'b0}.
  - exp ≥ 255: {sign,8'hFF,23'b0} (overflow to inf).
  - exp ≤ 0: {sign,31'b0} (underflow flushed).
  - Otherwise: {sign,exp[7:0],frac}.
- Latency: fixed, regardless of special cases.
  - start sampled at edge 0; done is high during the cycle after edge MANT_W+2, i.e. 26 cycles for the defaults.
- Back-to-back: start asserted in the done cycle is accepted, because the state is already IDLE.
- Operand changes after acceptance do not affect the in-flight operation.
- Default rounding: truncation (round toward zero).

Optional Feature:
- Macro: FP_MUL_ROUND_NEAREST_EN.
- Defined:
  - NORMALIZE also derives guard bit = first discarded bit and sticky = OR of the remaining discarded bits.
  - PACK rounds to nearest, ties to even. Increment frac when guard && (sticky || frac[0]).
  - If the increment carries out of frac, frac=0 and exp+1, re-checking overflow.
  - Latency is unchanged.
- Undefined: truncation only; guard/sticky logic is not synthesised.

Test Plan:
- a=0x40000000 (2.0), b=0x40400000 (3.0), start 1 cycle -> result=0x40C00000, done pulses exactly 26 cycles later for one cycle, busy high throughout.
- a=0x3FC00000, b=0x3FC00000 (1.5×1.5) -> 0x40100000 (normalize shift path). Then a=0xC0000000, b=0x3F000000 -> 0xBF800000; second start is issued in the done cycle and must be accepted.
- Specials:
  - 0x00000000×0x40A00000 -> 0x00000000.
  - 0x80000000×0x40A00000 -> 0x80000000.
  - 0x7F800000×0x00000000 -> 0x7FC00000.
  - 0x7F800000×0xC0000000 -> 0xFF800000.
- Range: 0x7F000000×0x7F000000 -> 0x7F800000 (overflow); 0x00800000×0x00800000 -> 0x00000000 (underflow).
- Rounding: 0x3FC00001×0x3FC00001 -> 0x40100001 without FP_MUL_ROUND_NEAREST_EN, 0x40100002 with it.
- Assert rst 10 cycles into an operation -> done never pulses, result=0, busy=0 immediately (asynchronous). A fresh start after release completes normally.

Source files
------------

// File: rtl/fp_multiplier.sv
// fp_multiplier
// Multi-cycle IEEE-754 single-precision multiplier, the multiplicative
// counterpart to the FPU's sequential divider, with the same start/done
// handshake. The mantissa product is built by a shift-and-add loop, one
// partial product per clock, so latency is fixed at MANT_W+2 cycles from
// acceptance to the done pulse, including special-case operands.
//
// Parameters:
//   MANT_W  mantissa width including hidden bit (24 for single precision)
//   BIAS    exponent bias (127)
//
// Ports:
//   clk     system clock, rising edge
//   rst     asynchronous, active-high reset (aborts any operation, no done)
//   a, b    IEEE-754 single operands, captured when start is accepted
//   start   request, sampled only while idle
//   result  product, held stable between done pulses
//   done    one-cycle pulse when result is updated
//   busy    high from start acceptance until the done cycle
//
// Build option:
//   FP_MUL_ROUND_NEAREST_EN  round to nearest, ties to even (default truncates)

module fp_multiplier #(
  parameter int MANT_W = 24,
  parameter int BIAS   = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic [31:0] result,
  output logic        done,
  output logic        busy
);

  localparam int FRAC_W = MANT_W - 1;
  localparam int PROD_W = 2 * MANT_W;
  localparam int CNT_W  = $clog2(MANT_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MANT_W - 1);
  localparam logic signed [9:0] BIAS_S   = 10'(BIAS);

  typedef enum logic [1:0] {
    IDLE,
    MULTIPLY,
    NORMALIZE,
    PACK
  } state_t;

  state_t state, state_d;

  logic              load, step, norm, pack;
  logic [31:0]       a_q, b_q;
  logic [CNT_W-1:0]  cnt;
  logic [PROD_W-1:0] acc;
  logic signed [9:0] exp_q;
  logic [FRAC_W-1:0] frac_q;
  logic [MANT_W-1:0] mant_a, mant_b;

  logic signed [9:0] exp_fin;
  logic [FRAC_W-1:0] frac_fin;
  logic [31:0]       result_d;

  logic sign;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Mantissas come straight from the captured operands; no separate copies.
  assign mant_a = {1'b1, a_q[FRAC_W-1:0]};
  assign mant_b = {1'b1, b_q[FRAC_W-1:0]};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    norm    = 1'b0;
    pack    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = MULTIPLY;
        end
      end
      MULTIPLY: begin
        step = 1'b1;
        if (cnt == LAST_CNT) begin
          state_d = NORMALIZE;
        end
      end
      NORMALIZE: begin
        norm    = 1'b1;
        state_d = PACK;
      end
      PACK: begin
        pack    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FP_MUL_ROUND_NEAREST_EN
  logic              guard_q, sticky_q;
  logic              round_up;
  logic [FRAC_W:0]   frac_inc;

  // Round to nearest even; a carry out of the fraction bumps the exponent,
  // which is then range-checked again by the packing logic below.
  always_comb begin
    round_up = guard_q & (sticky_q | frac_q[0]);
    frac_inc = {1'b0, frac_q} + {{FRAC_W{1'b0}}, round_up};
    frac_fin = frac_inc[FRAC_W-1:0];
    exp_fin  = exp_q + 10'(frac_inc[FRAC_W]);
  end
`else
  always_comb begin
    frac_fin = frac_q;
    exp_fin  = exp_q;
  end
`endif

  // Operand classification and result selection, highest priority first
  always_comb begin
    sign   = a_q[31] ^ b_q[31];
    a_nan  = (&a_q[30:23]) & (|a_q[22:0]);
    b_nan  = (&b_q[30:23]) & (|b_q[22:0]);
    a_inf  = (&a_q[30:23]) & ~(|a_q[22:0]);
    b_inf  = (&b_q[30:23]) & ~(|b_q[22:0]);
    a_zero = ~(|a_q[30:23]);
    b_zero = ~(|b_q[30:23]);

    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
      result_d = 32'h7FC0_0000;
    end else if (a_inf | b_inf) begin
      result_d = {sign, 8'hFF, 23'd0};
    end else if (a_zero | b_zero) begin
      result_d = {sign, 31'd0};
    end else if (exp_fin >= 10'sd255) begin
      result_d = {sign, 8'hFF, 23'd0};
    end else if (exp_fin <= 10'sd0) begin
      result_d = {sign, 31'd0};
    end else begin
      result_d = {sign, exp_fin[7:0], frac_fin};
    end
  end

  // Datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cnt      <= '0;
      acc      <= '0;
      exp_q    <= '0;
      frac_q   <= '0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
`ifdef FP_MUL_ROUND_NEAREST_EN
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      if (load) begin
        a_q   <= a;
        b_q   <= b;
        cnt   <= '0;
        acc   <= '0;
        busy  <= 1'b1;
        // 10-bit signed so both overflow past 254 and underflow below 1
        // remain visible at pack time.
        exp_q <= $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - BIAS_S;
      end

      if (step) begin
        if (mant_b[cnt]) begin
          acc <= acc + (PROD_W'(mant_a) << cnt);
        end
        cnt <= cnt + 1'b1;
      end

      if (norm) begin
        // Product of two [1,2) mantissas lies in [1,4); top bit picks the shift.
        if (acc[PROD_W-1]) begin
          frac_q   <= acc[PROD_W-2 -: FRAC_W];
          exp_q    <= exp_q + 10'sd1;
`ifdef FP_MUL_ROUND_NEAREST_EN
          guard_q  <= acc[MANT_W-1];
          sticky_q <= |acc[MANT_W-2:0];
`endif
        end else begin
          frac_q   <= acc[PROD_W-3 -: FRAC_W];
`ifdef FP_MUL_ROUND_NEAREST_EN
          guard_q  <= acc[MANT_W-2];
          sticky_q <= |acc[MANT_W-3:0];
`endif
        end
      end

      if (pack) begin
        result <= result_d;
        done   <= 1'b1;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_multiplier.sv
// tb_fp_multiplier
// Directed and randomised stimulus for fp_multiplier. A transaction-level
// reference (real integer multiply, remainder-based rounding, cycle-count
// latency) predicts done/busy/result every cycle; directed vectors also
// pin hand-computed results and the 26-cycle latency.

module tb_fp_multiplier;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        start = 1'b0;
  logic [31:0] result;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  fp_multiplier #(
    .MANT_W(24),
    .BIAS  (127)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .a     (a),
    .b     (b),
    .start (start),
    .result(result),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Reference product from the IEEE field rules
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e;
    logic s;
    logic [63:0] p;
    logic [22:0] f;
    bit xn, yn, xi, yi, xz, yz;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (x[22:0] != 23'd0);
    yn = (ey == 255) && (y[22:0] != 23'd0);
    xi = (ex == 255) && (x[22:0] == 23'd0);
    yi = (ey == 255) && (y[22:0] == 23'd0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    e = ex + ey - 127;
    if (p >= 64'h0000_8000_0000_0000) begin
      e = e + 1;
      f = p[46:24];
    end else begin
      f = p[45:23];
    end
`ifdef FP_MUL_ROUND_NEAREST_EN
    begin
      logic [63:0] rem, half;
      if (p[47]) begin
        rem  = p % 64'h100_0000;
        half = 64'h80_0000;
      end else begin
        rem  = p % 64'h80_0000;
        half = 64'h40_0000;
      end
      if (rem > half || (rem == half && f[0])) begin
        if (f == 23'h7F_FFFF) begin
          f = '0;
          e = e + 1;
        end else begin
          f = f + 23'd1;
        end
      end
    end
`endif
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0) return {s, 31'd0};
    return {s, e[7:0], f};
  endfunction

  // Cycle-level transaction model: accept when idle, done 26 edges later
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pending = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy   <= 1'b0;
      m_done   <= 1'b0;
      m_cnt    <= 0;
      m_result <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_cnt <= m_cnt + 1;
        if (m_cnt == 25) begin
          m_busy   <= 1'b0;
          m_done   <= 1'b1;
          m_result <= m_pending;
        end
      end else if (start) begin
        m_busy    <= 1'b1;
        m_cnt     <= 0;
        m_pending <= ref_mul(a, b);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("cyc done",   {31'd0, done}, {31'd0, m_done});
      check("cyc busy",   {31'd0, busy}, {31'd0, m_busy});
      check("cyc result", result,        m_result);
    end
  end

  // Issue one operation (DUT must be idle or in its done cycle) and wait
  // for done. disturb pulses start and changes operands mid-flight.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp_r, input bit lit,
                       input bit disturb, input string name);
    int k;
    bit seen;
    if (lit) check({name, " model"}, ref_mul(x, y), exp_r);
    a     = x;
    b     = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k     = 0;
    seen  = 1'b0;
    while (!seen && k < 40) begin
      k++;
      if (disturb && k == 5) begin
        a     = ~x;
        b     = 32'h4040_0000;
        start = 1'b1;
      end
      if (disturb && k == 6) start = 1'b0;
      @(posedge clk);
      #1;
      seen = done;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no done expected done within 40 cycles", name);
    end else begin
      check({name, " latency"}, 32'(k), 32'd26);
      check({name, " busy@done"}, {31'd0, busy}, 32'd0);
      if (lit) check({name, " result"}, result, exp_r);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [31:0] rx, ry;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("reset result", result, 32'd0);
    check("reset done",   {31'd0, done}, 32'd0);
    check("reset busy",   {31'd0, busy}, 32'd0);

    do_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 0, "2x3");
    do_op(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1, 0, "1.5x1.5");
    do_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1, 0, "b2b -2x0.5");
    do_op(32'h0000_0000, 32'h40A0_0000, 32'h0000_0000, 1, 0, "+0x5");
    do_op(32'h8000_0000, 32'h40A0_0000, 32'h8000_0000, 1, 0, "-0x5");
    do_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1, 0, "inf x 0");
    do_op(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 1, 0, "inf x -2");
    do_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1, 0, "nan x 1");
    do_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1, 0, "overflow");
    do_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1, 0, "underflow");
`ifdef FP_MUL_ROUND_NEAREST_EN
    do_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0002, 1, 0, "rounding");
`else
    do_op(32'h3FC0_0001, 32'h3FC0_0001, 32'h4010_0001, 1, 0, "rounding");
`endif
    do_op(32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1, 1, "ignored start");

    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 3) begin
        rx = $urandom;
        ry = $urandom;
      end else begin
        rx = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
        ry = {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
      end
      do_op(rx, ry, 32'd0, 0, 0, "random");
    end

    // Leave a nonzero result behind, then abort an operation with reset
    do_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 1, 0, "pre-abort");
    a     = 32'h3FC0_0000;
    b     = 32'h3FC0_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy",   {31'd0, busy}, 32'd0);
    check("abort done",   {31'd0, done}, 32'd0);
    check("abort result", result, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort no done", 32'(pulses), 32'd0);
    @(posedge clk);
    #1;
    do_op(32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1, 0, "post-abort");

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
